// File: rtl/instruction_fetch_stage_pkg.sv
// Shared ISA constants for the RV32I front end: machine widths, the canonical
// NOP encoding, the packet handed from fetch to decode and the fetch mode enum.
package instruction_fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] RV_NOP = 32'h0000_0013;

  // Packets that may be buffered or in flight between fetch and decode.
  localparam logic [2:0] FETCH_BUF_DEPTH = 3'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            misaligned;
  } fetch_packet_t;

  // RUN fetches sequentially; MIS_PUSH emits the single misaligned-target
  // packet; HALT waits for a redirect or reset.
  typedef enum logic [1:0] {
    FETCH_RUN      = 2'd0,
    FETCH_MIS_PUSH = 2'd1,
    FETCH_HALT     = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_fetch_buffer.sv
// fetch_buffer: 2-entry synchronous FIFO of fetch packets between the
// instruction memory response and the decoder. Flush discards everything and
// wins over a simultaneous push or pop.
module fetch_buffer
  import instruction_fetch_stage_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_packet_t push_data_i,
  input  logic          pop_i,
  output fetch_packet_t head_o,
  output logic [1:0]    occ_o
);

  fetch_packet_t slot_q [2];
  logic          rdPtr_q, rdPtr_d;
  logic          wrPtr_q, wrPtr_d;
  logic [1:0]    occ_q, occ_d;
  logic          doPush, doPop;

  // Qualify push/pop against occupancy and compute next pointers and count.
  always_comb begin
    doPush  = push_i && (occ_q != 2'd2);
    doPop   = pop_i && (occ_q != 2'd0);
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    occ_d   = occ_q;
    if (flush_i) begin
      rdPtr_d = 1'b0;
      wrPtr_d = 1'b0;
      occ_d   = 2'd0;
    end else begin
      if (doPush) wrPtr_d = ~wrPtr_q;
      if (doPop)  rdPtr_d = ~rdPtr_q;
      occ_d = occ_q + {1'b0, doPush} - {1'b0, doPop};
    end
  end

  // Packet storage; cleared on reset so the head reads as all zeros.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else if (doPush && !flush_i) begin
      slot_q[wrPtr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdPtr_q <= 1'b0;
      wrPtr_q <= 1'b0;
      occ_q   <= 2'd0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      occ_q   <= occ_d;
    end
  end

  assign head_o = slot_q[rdPtr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: RV32I front end. Owns the PC, issues word reads to
// a one-cycle synchronous instruction memory and hands {pc, instr} packets to
// decode through a 2-entry buffer. A redirect flushes all speculative state.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect targets
// produce a single flagged NOP packet and halt fetch; otherwise the low target
// bits are cleared and out_misaligned is tied low).
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_misaligned,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflightPc_q, inflightPc_d;
  fetch_state_e    state_q, state_d;

  logic [XLEN-1:0] redirectTarget;
  logic            redirectMisaligned;
  logic            pop;
  logic [2:0]      outstanding;
  logic            pushValid;
  fetch_packet_t   pushData;
  fetch_packet_t   head;
  logic [1:0]      fifoOcc;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MISALIGN_EN = 1'b1;
  assign redirectTarget     = redirect_pc;
  assign redirectMisaligned = (redirect_pc[1:0] != 2'b00);
`else
  localparam bit MISALIGN_EN = 1'b0;
  assign redirectTarget     = word_align(redirect_pc);
  assign redirectMisaligned = 1'b0;
`endif

  // Issue decision and response capture; issue only while buffer plus in-flight stays below two after this cycle's pop.
  always_comb begin
    pop         = out_valid && out_ready;
    outstanding = {1'b0, fifoOcc} + {2'b00, inflight_q} - {2'b00, pop};
    imem_req    = rst_n && !redirect_valid && (state_q == FETCH_RUN)
                  && (outstanding < FETCH_BUF_DEPTH);
    pushValid   = 1'b0;
    pushData    = '0;
    if (state_q == FETCH_MIS_PUSH) begin
      pushValid           = 1'b1;
      pushData.pc         = pc_q;
      pushData.instr      = RV_NOP;
      pushData.misaligned = 1'b1;
    end else if (inflight_q) begin
      pushValid           = 1'b1;
      pushData.pc         = inflightPc_q;
      pushData.instr      = imem_rdata;
      pushData.misaligned = 1'b0;
    end
  end

  // Next PC, in-flight tracking and fetch mode; redirect overrides everything.
  always_comb begin
    pc_d         = pc_q;
    inflight_d   = 1'b0;
    inflightPc_d = inflightPc_q;
    state_d      = state_q;
    if (state_q == FETCH_MIS_PUSH) begin
      state_d = FETCH_HALT;
    end
    if (imem_req) begin
      inflight_d   = 1'b1;
      inflightPc_d = pc_q;
      pc_d         = pc_q + XLEN'(4);
    end
    if (redirect_valid) begin
      pc_d    = redirectTarget;
      state_d = redirectMisaligned ? FETCH_MIS_PUSH : FETCH_RUN;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      inflight_q   <= 1'b0;
      inflightPc_q <= '0;
      state_q      <= FETCH_RUN;
    end else begin
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      inflightPc_q <= inflightPc_d;
      state_q      <= state_d;
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (pushValid),
    .push_data_i (pushData),
    .pop_i       (pop),
    .head_o      (head),
    .occ_o       (fifoOcc)
  );

  assign imem_addr      = word_align(pc_q);
  assign out_valid      = (fifoOcc != 2'd0);
  assign out_pc         = head.pc;
  assign out_instr      = head.instr;
  assign out_misaligned = MISALIGN_EN && head.misaligned;

endmodule
